// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions for the pipelined MIPS datapath.
// Provides:
//   word_t           32-bit machine word
//   opcode_t/funct_t field views of an instruction word
//   PC_INIT_DEFAULT  reset value of the program counter
//   fetch_state_t    fetch-stage FSM states
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Field extraction helpers for decode
  function automatic opcode_t instr_opcode(input word_t instr);
    return instr[31:26];
  endfunction

  function automatic funct_t instr_funct(input word_t instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   en_i      update enable (low while decode is stalled)
//   flush_i   insert a bubble; wins over en_i
//   load_i    a fetched instruction is available this cycle
//   instr_i   fetched instruction word
//   npc_i     pc+4 of the fetched instruction
//   valid_o   register holds a live instruction
//   instr_o   latched instruction word
//   npc_o     latched pc+4
module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  flush_i,
  input  logic  load_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t npc_o
);

  logic  valid_q;
  word_t instr_q;
  word_t npc_q;

  // A flush only kills the valid bit; instr/npc keep their old contents so
  // decode sees stable (but ignored) fields during a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      npc_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        instr_q <= instr_i;
        npc_q   <= npc_i;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, issues instruction
// memory reads and fills the IF/ID register. Honors stall, redirect, halt.
// Ports:
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   ihit         instruction memory returned iload for imemaddr
//   iload        instruction word from memory
//   stall        hold PC and IF/ID
//   redirect     taken branch/jump/jr; load redirect_pc
//   redirect_pc  target PC (bits [1:0] ignored)
//   halt         stop fetching until reset
//   imemREN      instruction read request
//   imemaddr     fetch address (= pc)
//   ifid_valid   IF/ID holds a live instruction
//   ifid_instr   latched instruction
//   ifid_npc     pc+4 of latched instruction
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_npc
);

  fetch_state_t state_q;
  word_t        pc_q;
  word_t        pc_d;
  word_t        pc_plus4;
  logic         halted;

  assign halted   = (state_q == HALTED);
  assign pc_plus4 = pc_q + 32'd4;

  // Priority: halt > redirect > stall > ihit > miss. Masking the target keeps
  // pc word aligned regardless of what the branch unit sends.
  always_comb begin
    pc_d = pc_q;
    if (!halted && !halt) begin
      if (redirect)
        pc_d = redirect_pc & ~32'h3;
      else if (!stall && ihit)
        pc_d = pc_plus4;
    end
  end

  // State and pc share one register block; HALTED is left only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT & ~32'h3;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        FETCH:   if (halt) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Gating with nRST keeps the request quiet while reset is held.
  assign imemREN  = nRST && !halted;
  assign imemaddr = pc_q;

  ifid_reg u_ifid (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (!stall),
    .flush_i (halt || redirect || halted),
    .load_i  (ihit),
    .instr_i (iload),
    .npc_i   (pc_plus4),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .npc_o   (ifid_npc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model state
  logic [31:0] mPc;
  logic        mHalted;
  logic        mValid;
  logic [31:0] mInstr;
  logic [31:0] mNpc;

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_npc    (ifid_npc)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic modelReset();
    mPc     = PC_INIT;
    mHalted = 1'b0;
    mValid  = 1'b0;
    mInstr  = 32'h0;
    mNpc    = 32'h0;
  endtask

  // One rising edge of the stage as described by its priority rules
  task automatic modelEdge();
    if (!mHalted) begin
      if (halt) begin
        mHalted = 1'b1;
        mValid  = 1'b0;
      end else if (redirect) begin
        mPc    = {redirect_pc[31:2], 2'b00};
        mValid = 1'b0;
      end else if (stall) begin
        // everything holds
      end else if (ihit) begin
        mInstr = iload;
        mNpc   = mPc + 32'd4;
        mValid = 1'b1;
        mPc    = mPc + 32'd4;
      end else begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".imemREN"},    {31'b0, imemREN},    {31'b0, nRST && !mHalted});
    checkValue({tag, ".imemaddr"},   imemaddr,            mPc);
    checkValue({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, mValid});
    checkValue({tag, ".ifid_instr"}, ifid_instr,          mInstr);
    checkValue({tag, ".ifid_npc"},   ifid_npc,            mNpc);
  endtask

  // Drive one cycle of inputs, clock it, then compare just after the edge
  task automatic applyStimulus(input string tag, input logic h, input logic [31:0] ld,
                               input logic st, input logic rd, input logic [31:0] rpc,
                               input logic hl);
    ihit        = h;
    iload       = ld;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    @(posedge CLK);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset pulse issued away from the clock edge
  task automatic pulseReset(input string tag);
    nRST = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".inReset"});
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput({tag, ".released"});
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; iload = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    modelReset();
    #3;
    checkOutput("reset");
    nRST = 1'b1;
    #1;
    checkOutput("resetRelease");

    // Back-to-back hits
    applyStimulus("hit0", 1, 32'h20010001, 0, 0, 0, 0);
    applyStimulus("hit1", 1, 32'h20020002, 0, 0, 0, 0);
    checkValue("hitAddr8", imemaddr, 32'h8);
    checkValue("hitNpc8",  ifid_npc, 32'h8);

    // Three misses at pc=8, then resume
    for (int i = 0; i < 3; i++) applyStimulus("miss", 0, 32'hDEADBEEF, 0, 0, 0, 0);
    applyStimulus("resume", 1, 32'h20030003, 0, 0, 0, 0);

    // Stall with ihit at pc=12, then release
    applyStimulus("stall0", 1, 32'h11111111, 1, 0, 0, 0);
    applyStimulus("stall1", 1, 32'h22222222, 1, 0, 0, 0);
    checkValue("stallAddr", imemaddr, 32'hC);
    applyStimulus("stallRel", 1, 32'h20040004, 0, 0, 0, 0);
    checkValue("stallRelNpc", ifid_npc, 32'h10);

    // Redirect with concurrent ihit and stall
    applyStimulus("redir", 1, 32'hBADBAD00, 1, 1, 32'h00000103, 0);
    checkValue("redirAddr", imemaddr, 32'h100);
    applyStimulus("redirHold", 1, 32'hBADBAD01, 1, 1, 32'h00000207, 0);
    applyStimulus("redirHit", 1, 32'h20050005, 0, 0, 0, 0);

    // Wrap at the top of the address space
    applyStimulus("wrapRedir", 0, 0, 0, 1, 32'hFFFFFFFF, 0);
    applyStimulus("wrapHit", 1, 32'h20060006, 0, 0, 0, 0);
    checkValue("wrapNpc",  ifid_npc, 32'h0);
    checkValue("wrapAddr", imemaddr, 32'h0);

    // Halt, then try to disturb it
    applyStimulus("halt", 1, 32'h0000000C, 0, 0, 0, 1);
    checkValue("haltREN", {31'b0, imemREN}, 32'h0);
    applyStimulus("haltHit", 1, 32'h12345678, 0, 0, 0, 0);
    applyStimulus("haltRedir", 1, 32'h12345678, 0, 1, 32'h40, 0);
    pulseReset("haltReset");
    checkValue("haltResetPc", imemaddr, PC_INIT);

    // Reset asserted in the middle of a miss
    applyStimulus("preMiss", 1, 32'h20070007, 0, 0, 0, 0);
    applyStimulus("miss2", 0, 0, 0, 0, 0, 0);
    pulseReset("midMiss");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
      if (mHalted && $urandom_range(0, 3) == 0) begin
        pulseReset("rndReset");
      end else begin
        applyStimulus("rnd",
                      ($urandom_range(0, 9) < 7),
                      $urandom,
                      ($urandom_range(0, 9) < 2),
                      ($urandom_range(0, 9) == 0),
                      rpc,
                      ($urandom_range(0, 49) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
